// File: rtl/clkdiv_ctrl.sv
// Run/stop and divisor controller for the quadrature clock divider: produces 0/90-degree
// divided phases and edge strobes, with run-time divisor changes applied only at period wraps.
module clkdiv_ctrl #(
   parameter int WIDTH       = 16,
   parameter int DEFAULT_DIV = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             run,
   input  logic             div_req,
   input  logic [WIDTH-1:0] div_value,
   output logic             div_ack,
   output logic             div_err,
   output logic             busy,
   output logic             phase_0,
   output logic             phase_90,
   output logic             en_0,
   output logic             en_90,
   output logic [1:0]       dbg_state
);

   // Handshake: a request is the 0->1 edge of div_req with div_value sampled in that cycle;
   // it is answered by exactly one div_ack or div_err pulse, except edges seen while busy,
   // which are ignored. The requester holds div_req until the answer and then drops it.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] DEF_N = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
   localparam logic [WIDTH-1:0] MIN_N = WIDTH'(4);

   state_t           state;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] n_active;
   logic [WIDTH-1:0] n_pend;
   logic [WIDTH-1:0] cnt_inc;
   logic             req_q;
   logic             req_edge;
   logic             req_ok;
   logic             take_req;
   logic             at_wrap;

   assign req_edge  = div_req & ~req_q;
   assign req_ok    = (div_value >= MIN_N) && (div_value[1:0] == 2'b00);
   assign take_req  = req_edge & req_ok & (state != PEND);
   assign at_wrap   = (cnt == n_active - ONE);
   assign cnt_inc   = at_wrap ? '0 : cnt + ONE;
   assign dbg_state = state;

   // Output pattern for a given count under divisor n: {phase_0, phase_90, en_0, en_90}.
   function automatic logic [3:0] decode(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] n);
      logic [WIDTH-1:0] half;
      logic [WIDTH-1:0] quart;
      half   = n >> 1;
      quart  = n >> 2;
      decode = {c < half, (c >= quart) && (c < half + quart), c == '0, c == quart};
   endfunction

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         cnt      <= '0;
         n_active <= DEF_N;
         n_pend   <= DEF_N;
         req_q    <= 1'b0;
         div_ack  <= 1'b0;
         div_err  <= 1'b0;
         busy     <= 1'b0;
         {phase_0, phase_90, en_0, en_90} <= 4'b0000;
      end else begin
         req_q   <= div_req;
         div_ack <= 1'b0;
         div_err <= req_edge & ~req_ok & (state != PEND);
         if (!run) begin
            // Stopping truncates the period; a pending divisor is committed on the way out.
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            {phase_0, phase_90, en_0, en_90} <= 4'b0000;
            if (state == PEND) begin
               n_active <= n_pend;
               div_ack  <= 1'b1;
            end else if (take_req) begin
               n_active <= div_value;
               div_ack  <= 1'b1;
            end
         end else begin
            case (state)
               IDLE: begin
                  state <= RUN;
                  cnt   <= '0;
                  if (take_req) begin
                     n_active <= div_value;
                     div_ack  <= 1'b1;
                     {phase_0, phase_90, en_0, en_90} <= decode('0, div_value);
                  end else begin
                     {phase_0, phase_90, en_0, en_90} <= decode('0, n_active);
                  end
               end
               RUN: begin
                  cnt <= cnt_inc;
                  {phase_0, phase_90, en_0, en_90} <= decode(cnt_inc, n_active);
                  if (take_req) begin
                     state  <= PEND;
                     n_pend <= div_value;
                     busy   <= 1'b1;
                  end
               end
               PEND: begin
                  if (at_wrap) begin
                     state    <= RUN;
                     cnt      <= '0;
                     n_active <= n_pend;
                     div_ack  <= 1'b1;
                     busy     <= 1'b0;
                     {phase_0, phase_90, en_0, en_90} <= decode('0, n_pend);
                  end else begin
                     cnt <= cnt_inc;
                     {phase_0, phase_90, en_0, en_90} <= decode(cnt_inc, n_active);
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
                  {phase_0, phase_90, en_0, en_90} <= 4'b0000;
               end
            endcase
         end
      end
   end

endmodule
